// File: rtl/dec38_pulse_pkg.sv
// -----------------------------------------------------------------------------
// dec38_pulse_pkg
// Shared definitions for the one-hot decoder / priority encoder family:
//   - state_t   : FSM state encoding (IDLE, DRIVE, GAP) on 2 bits
//   - clog2     : ceiling log2 usable in constant expressions
//   - cnt_width : counter width able to hold max(hold, gap)
// -----------------------------------------------------------------------------
package dec38_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int w;
        w = 32'sd0;
        while ((32'sd1 << w) < value) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

    // Width of a down-counter that must be loaded with up to max(hold, gap).
    // Never narrower than one bit so the counter always exists.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        int w;
        m = (hold > gap) ? hold : gap;
        w = clog2(m + 32'sd1);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/dec38_pulse_comb.sv
// -----------------------------------------------------------------------------
// dec38_pulse_comb
// Purely combinational CW-to-N one-hot decoder (N = 2**CW).
// Ports:
//   code   : input  [CW-1:0]  binary code
//   onehot : output [N-1:0]   exactly one bit set, at position code
// -----------------------------------------------------------------------------
module dec38_pulse_comb #(
    parameter int CW = 3
) (
    input  logic [CW-1:0]      code,
    output logic [(2**CW)-1:0] onehot
);

    // Single bit set at the position selected by code.
    always_comb begin
        onehot       = {(2**CW){1'b0}};
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/dec38_pulse.sv
// -----------------------------------------------------------------------------
// dec38_pulse
// Sequential 3-to-8 decoder: accepts a code over valid/ready, drives the
// matching one-hot line for HOLD cycles, then forces GAP idle cycles before
// the next code can be accepted.
// Ports:
//   clk      : input         rising-edge clock
//   rst_n    : input         asynchronous active-low reset
//   en       : input         enable; low aborts any operation, blocks accept
//   in_valid : input         code valid from upstream
//   in_code  : input  [CW]   code to decode
//   in_ready : output        block can accept a code this cycle
//   y        : output [N]    registered one-hot output, zero when idle
//   busy     : output        high in DRIVE or GAP
//   done     : output        pulse on the last cycle of a completed DRIVE
// -----------------------------------------------------------------------------
module dec38_pulse
    import dec38_pulse_pkg::*;
#(
    parameter int CW   = 3,
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic [CW-1:0]       in_code,
    output logic                in_ready,
    output logic [(2**CW)-1:0]  y,
    output logic                busy,
    output logic                done
);

    localparam int N    = 2**CW;
    localparam int CNTW = cnt_width(HOLD, GAP);

    // Counter reload values; the counter runs down to zero, so a phase of
    // length L loads L-1.  GAP_LOAD is unused when GAP is zero.
    localparam logic [CNTW-1:0] HOLD_LOAD = CNTW'(HOLD - 1);
    localparam logic [CNTW-1:0] GAP_LOAD  = CNTW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [CNTW-1:0] CNT_ZERO  = CNTW'(0);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic            HOLD_IS_ONE = (HOLD == 1);

    generate
        if (HOLD < 1 || GAP < 0) begin : g_param_check
            $error("dec38_pulse: HOLD must be >= 1 and GAP must be >= 0");
        end
    endgenerate

    state_t          state_r;
    logic [CNTW-1:0] cnt_r;
    logic [N-1:0]    y_r;
    logic            busy_r;
    logic            done_r;
    logic [N-1:0]    decoded_s;

    dec38_pulse_comb #(
        .CW (CW)
    ) u_comb (
        .code   (in_code),
        .onehot (decoded_s)
    );

    // rst_n is included so ready is low for the whole reset, not just after
    // the state registers have cleared.
    assign in_ready = rst_n && en && (state_r == ST_IDLE);

    assign y    = y_r;
    assign busy = busy_r;
    assign done = done_r;

    // FSM, phase counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            y_r     <= {N{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (!en) begin
            // Abort: drop everything, an aborted drive never reports done.
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            y_r     <= {N{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // en is high and reset is released here, so ready
                    // reduces to being in IDLE.
                    if (in_valid) begin
                        state_r <= ST_DRIVE;
                        cnt_r   <= HOLD_LOAD;
                        y_r     <= decoded_s;
                        busy_r  <= 1'b1;
                        // A one-cycle drive is already on its last cycle.
                        done_r  <= HOLD_IS_ONE;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        y_r     <= {N{1'b0}};
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r  <= cnt_r - CNT_ONE;
                        // done lines up with the cycle where cnt reaches 0.
                        done_r <= (cnt_r == CNT_ONE);
                    end else begin
                        y_r    <= {N{1'b0}};
                        done_r <= 1'b0;
                        if (GAP > 0) begin
                            state_r <= ST_GAP;
                            cnt_r   <= GAP_LOAD;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            cnt_r   <= CNT_ZERO;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    y_r     <= {N{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec38_pulse.sv
// -----------------------------------------------------------------------------
// tb_dec38_pulse
// Directed bench for dec38_pulse: one instance at HOLD=4/GAP=1 and one at
// HOLD=1/GAP=0.  Outputs are sampled 1 time unit after the rising edge;
// "cycle c" below means the period that follows the c-th edge after accept.
// -----------------------------------------------------------------------------
module tb_dec38_pulse;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = 3'd0;
    logic       in_ready;
    logic [7:0] y;
    logic       busy;
    logic       done;

    logic       en2 = 1'b0;
    logic       in_valid2 = 1'b0;
    logic [2:0] in_code2 = 3'd0;
    logic       in_ready2;
    logic [7:0] y2;
    logic       busy2;
    logic       done2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dec38_pulse #(.CW(3), .HOLD(4), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .in_code(in_code), .in_ready(in_ready), .y(y), .busy(busy), .done(done)
    );

    dec38_pulse #(.CW(3), .HOLD(1), .GAP(0)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .en(en2), .in_valid(in_valid2),
        .in_code(in_code2), .in_ready(in_ready2), .y(y2), .busy(busy2), .done(done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_code = 3'd2;
        en2 = 1'b1; in_valid2 = 1'b0;
        tick(); tick();
        total++;
        if (in_ready !== 1'b0 || y !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_hold: rdy=%b y=%h busy=%b done=%b expected 0 00 0 0", in_ready, y, busy, done);
        else passed++;
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        else passed++;
        tick();
        total++;
        if (y !== 8'h04) $display("FAIL reset_accept_y: got %h expected 04", y);
        else passed++;
        // Mid-clock reset: outputs must clear with no clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_async: y=%h busy=%b done=%b rdy=%b expected 00 0 0 0", y, busy, done, in_ready);
        else passed++;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || y !== 8'h00 || busy !== 1'b0)
            $display("FAIL reset_after: rdy=%b y=%h busy=%b expected 1 00 0", in_ready, y, busy);
        else passed++;
    endtask

    task automatic test_single();
        logic [7:0] ye;
        total++;
        if (in_ready !== 1'b1) $display("FAIL single_pre_ready: got %b expected 1", in_ready);
        else passed++;
        in_code = 3'd3; in_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            in_valid = 1'b0;
            ye = (c <= 4) ? 8'h08 : 8'h00;
            total++;
            if (y !== ye || done !== (c == 4) || busy !== (c <= 5) || in_ready !== (c == 6))
                $display("FAIL single c=%0d: y=%h done=%b busy=%b rdy=%b expected %h %b %b %b",
                         c, y, done, busy, in_ready, ye, (c == 4), (c <= 5), (c == 6));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ye;
        int accept_cycle;
        accept_cycle = -1;
        in_code = 3'd0; in_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) in_code = 3'd7;
            if (c == 8) in_valid = 1'b0;
            if (c <= 4) ye = 8'h01;
            else if (c <= 6) ye = 8'h00;
            else if (c <= 10) ye = 8'h80;
            else ye = 8'h00;
            total++;
            if (y !== ye || (y & (y - 8'd1)) !== 8'h00)
                $display("FAIL b2b_y c=%0d: got %h expected %h", c, y, ye);
            else passed++;
            if (in_ready && in_valid && accept_cycle < 0) accept_cycle = c;
        end
        // Second accept happens on the edge ending cycle 6: HOLD drive
        // cycles, GAP idle cycles, then one IDLE cycle where ready is seen.
        total++;
        if (accept_cycle !== 6) $display("FAIL b2b_spacing: got %0d expected 6", accept_cycle);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL b2b_final_ready: got %b expected 1", in_ready);
        else passed++;
    endtask

    task automatic test_abort();
        in_code = 3'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (y !== 8'h20 || busy !== 1'b1) $display("FAIL abort_c1: y=%h busy=%b expected 20 1", y, busy);
        else passed++;
        tick();
        total++;
        if (y !== 8'h20 || done !== 1'b0) $display("FAIL abort_c2: y=%h done=%b expected 20 0", y, done);
        else passed++;
        en = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL abort_ready_low: got %b expected 0", in_ready);
        else passed++;
        tick();
        total++;
        if (y !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL abort_cleared: y=%h busy=%b done=%b rdy=%b expected 00 0 0 0", y, busy, done, in_ready);
        else passed++;
        en = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL abort_ready_back: got %b expected 1", in_ready);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (done !== 1'b0 || y !== 8'h00) $display("FAIL abort_quiet c=%0d: done=%b y=%h expected 0 00", c, done, y);
            else passed++;
        end
    endtask

    task automatic test_async_reset_drive();
        in_code = 3'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (y !== 8'h40) $display("FAIL areset_drive_y: got %h expected 40", y);
        else passed++;
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (y !== 8'h00 || busy !== 1'b0) $display("FAIL areset_clear: y=%h busy=%b expected 00 0", y, busy);
        else passed++;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (done !== 1'b0 || y !== 8'h00 || in_ready !== 1'b1)
                $display("FAIL areset_quiet c=%0d: done=%b y=%h rdy=%b expected 0 00 1", c, done, y, in_ready);
            else passed++;
        end
        in_code = 3'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (y !== 8'h02 || busy !== 1'b1) $display("FAIL areset_reaccept: y=%h busy=%b expected 02 1", y, busy);
        else passed++;
        repeat (5) tick();
        total++;
        if (in_ready !== 1'b1 || y !== 8'h00) $display("FAIL areset_end: rdy=%b y=%h expected 1 00", in_ready, y);
        else passed++;
    endtask

    task automatic test_hold1_sweep();
        logic [7:0] ye;
        in_valid2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (in_ready2 !== 1'b1) $display("FAIL h1_ready code=%0d: got %b expected 1", i, in_ready2);
            else passed++;
            in_code2 = 3'(i);
            ye = 8'h01 << i;
            tick();
            total++;
            if (y2 !== ye || done2 !== 1'b1 || busy2 !== 1'b1 || in_ready2 !== 1'b0)
                $display("FAIL h1_drive code=%0d: y=%h done=%b busy=%b rdy=%b expected %h 1 1 0",
                         i, y2, done2, busy2, in_ready2, ye);
            else passed++;
            tick();
            total++;
            if (y2 !== 8'h00 || done2 !== 1'b0 || busy2 !== 1'b0)
                $display("FAIL h1_idle code=%0d: y=%h done=%b busy=%b expected 00 0 0", i, y2, done2, busy2);
            else passed++;
        end
        in_valid2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_async_reset_drive();
        test_hold1_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
